dma_sd_tx: RTL and testbench

- Memory-to-SD DMA engine occupying the free sequencer slot 3: req3/addr3/rnw3/ack3/end3.
- Reads BLOCK_LEN bytes from the 22-bit DMA address space through the DMA sequencer.
- Streams the bytes through a 2-entry prefetch buffer into the SD SPI master, which receives sd_start as an OR with the existing SD start sources.
- Programmed through the shared DMA register bus (din/regsel/write_strobe/module_select); raises a completion strobe into the interrupt controller.

---
 rtl/dma_sd_tx_if.sv | 30 +++
 rtl/dma_sd_tx.sv | 200 ++++++++++++++++++++
 tb/tb_dma_sd_tx.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_sd_tx_if.sv
// Register bus, DMA sequencer slot 3 and SD SPI handshake signals of the memory-to-SD engine.
// The engine uses the slave modport; the surrounding system (or bench) uses the master modport.
interface dma_sd_tx_if;
  logic        module_select;
  logic        write_strobe;
  logic [1:0]  regsel;
  logic [7:0]  din;
  logic [7:0]  dout;
  logic        sd_start;
  logic [7:0]  sd_senddata;
  logic        sd_rdy;
  logic        dma_req;
  logic [21:0] dma_addr;
  logic        dma_rnw;
  logic        dma_ack;
  logic        dma_end;
  logic [7:0]  dma_rd;
  logic        int_req;
  logic        busy;

  modport slave (
    input  module_select, write_strobe, regsel, din, sd_rdy, dma_ack, dma_end, dma_rd,
    output dout, sd_start, sd_senddata, dma_req, dma_addr, dma_rnw, int_req, busy
  );

  modport master (
    output module_select, write_strobe, regsel, din, sd_rdy, dma_ack, dma_end, dma_rd,
    input  dout, sd_start, sd_senddata, dma_req, dma_addr, dma_rnw, int_req, busy
  );
endinterface

// File: rtl/dma_sd_tx.sv
// Memory-to-SD DMA: fetches BLOCK_LEN bytes via sequencer slot 3 and streams them to the SPI master.
// Define DMA_SD_TX_CRC_EN to append CRC16-CCITT (MSB first, init 0) as two trailing SPI bytes.
module dma_sd_tx #(
  parameter int BLOCK_LEN = 512,
  parameter int CNT_W     = 11
) (
  input  logic       clk,
  input  logic       rst_n,
  dma_sd_tx_if.slave bus
);

  typedef enum logic [1:0] {F_IDLE, F_REQ, F_WAIT} fetch_state_t;
  typedef enum logic [1:0] {S_IDLE, S_START, S_SKIP, S_WAIT} send_state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLOCK_LEN);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  fetch_state_t     r_fstate, w_fstate_next;
  send_state_t      r_sstate, w_sstate_next;
  logic [21:0]      r_addr;
  logic [CNT_W-1:0] r_fetched, r_sent;
  logic [7:0]       r_buf [2];
  logic             r_wptr, r_rptr;
  logic [1:0]       r_count;
  logic [7:0]       r_senddata;
  logic             r_busy, r_abort, r_int_req;

  logic       w_reg_wr, w_start, w_abort_wr, w_stopping;
  logic       w_ack_take, w_push, w_pop, w_load;
  logic       w_data_done, w_extra_pending, w_all_sent, w_done;
  logic [7:0] w_load_byte;

  assign w_reg_wr    = bus.module_select & bus.write_strobe;
  assign w_start     = w_reg_wr && (bus.regsel == 2'd3) && bus.din[0] && !r_busy;
  assign w_abort_wr  = w_reg_wr && (bus.regsel == 2'd3) && !bus.din[0] && r_busy;
  assign w_stopping  = r_abort | w_abort_wr;
  assign w_data_done = (r_sent == CNT_LAST);
  assign w_pop       = (r_sstate == S_START) && !w_data_done;
  assign w_all_sent  = w_data_done && !w_extra_pending;
  assign w_done      = r_busy && !w_stopping && (r_sstate == S_IDLE) && bus.sd_rdy && w_all_sent;

`ifdef DMA_SD_TX_CRC_EN
  logic [15:0] r_crc;
  logic [1:0]  r_crc_cnt;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] v;
    v = c ^ {d, 8'h00};
    for (int i = 0; i < 8; i++) v = v[15] ? ((v << 1) ^ 16'h1021) : (v << 1);
    return v;
  endfunction

  assign w_extra_pending = w_data_done && (r_crc_cnt != 2'd2);
  assign w_load_byte     = !w_data_done ? r_buf[r_rptr] :
                           (r_crc_cnt == 2'd0) ? r_crc[15:8] : r_crc[7:0];

  // CRC covers data bytes only; the trailing CRC bytes just advance r_crc_cnt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_crc     <= '0;
      r_crc_cnt <= '0;
    end else if (w_start) begin
      r_crc     <= '0;
      r_crc_cnt <= '0;
    end else if (r_sstate == S_START) begin
      if (w_pop) r_crc <= crc_step(r_crc, r_senddata);
      else       r_crc_cnt <= r_crc_cnt + 2'd1;
    end
  end
`else
  assign w_extra_pending = 1'b0;
  assign w_load_byte     = r_buf[r_rptr];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fstate <= F_IDLE;
      r_sstate <= S_IDLE;
    end else begin
      r_fstate <= w_fstate_next;
      r_sstate <= w_sstate_next;
    end
  end

  // Only one read outstanding, so occupancy < 2 in F_IDLE guarantees room for the reply.
  always_comb begin
    w_fstate_next = r_fstate;
    w_ack_take    = 1'b0;
    w_push        = 1'b0;
    unique case (r_fstate)
      F_IDLE: if (r_busy && !w_stopping && (r_fetched < CNT_LAST) && (r_count != 2'd2))
                w_fstate_next = F_REQ;
      F_REQ: begin
        if (bus.dma_ack) begin
          w_ack_take    = 1'b1;
          w_fstate_next = F_WAIT;
        end else if (w_abort_wr) begin
          w_fstate_next = F_IDLE;
        end
      end
      F_WAIT: if (bus.dma_end) begin
        w_push        = !w_stopping;
        w_fstate_next = F_IDLE;
      end
      default: w_fstate_next = F_IDLE;
    endcase
  end

  always_comb begin
    w_sstate_next = r_sstate;
    w_load        = 1'b0;
    unique case (r_sstate)
      S_IDLE: if (r_busy && !w_stopping && bus.sd_rdy &&
                  ((!w_data_done && (r_count != 2'd0)) || w_extra_pending)) begin
        w_load        = 1'b1;
        w_sstate_next = S_START;
      end
      S_START: w_sstate_next = S_SKIP;
      S_SKIP:  w_sstate_next = S_WAIT;
      S_WAIT:  if (bus.sd_rdy) w_sstate_next = S_IDLE;
      default: w_sstate_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr     <= '0;
      r_fetched  <= '0;
      r_sent     <= '0;
      r_wptr     <= 1'b0;
      r_rptr     <= 1'b0;
      r_count    <= '0;
      r_senddata <= '0;
      r_busy     <= 1'b0;
      r_abort    <= 1'b0;
      r_int_req  <= 1'b0;
    end else begin
      r_int_req <= w_done;
      if (w_start) begin
        r_busy    <= 1'b1;
        r_abort   <= 1'b0;
        r_fetched <= '0;
        r_sent    <= '0;
        r_wptr    <= 1'b0;
        r_rptr    <= 1'b0;
        r_count   <= '0;
      end else begin
        if (w_done || (r_abort && (r_fstate == F_IDLE) && (r_sstate == S_IDLE))) begin
          r_busy  <= 1'b0;
          r_abort <= 1'b0;
        end else if (w_abort_wr) begin
          r_abort <= 1'b1;
        end
        if (w_ack_take) begin
          r_addr    <= r_addr + 22'd1;
          r_fetched <= r_fetched + CNT_ONE;
        end
        if (w_push) r_wptr <= ~r_wptr;
        if (w_pop) begin
          r_rptr <= ~r_rptr;
          r_sent <= r_sent + CNT_ONE;
        end
        if (w_push && !w_pop)      r_count <= r_count + 2'd1;
        else if (w_pop && !w_push) r_count <= r_count - 2'd1;
      end
      if (w_load) r_senddata <= w_load_byte;
      if (w_reg_wr && !r_busy) begin
        case (bus.regsel)
          2'd0:    r_addr[7:0]   <= bus.din;
          2'd1:    r_addr[15:8]  <= bus.din;
          2'd2:    r_addr[21:16] <= bus.din[5:0];
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_buf[r_wptr] <= bus.dma_rd;
  end

  always_comb begin
    bus.dout = 8'h00;
    case (bus.regsel)
      2'd0:    bus.dout = r_addr[7:0];
      2'd1:    bus.dout = r_addr[15:8];
      2'd2:    bus.dout = {2'b00, r_addr[21:16]};
      default: bus.dout = {r_busy, r_busy && w_extra_pending, 6'b000000};
    endcase
  end

  assign bus.sd_start    = (r_sstate == S_START);
  assign bus.sd_senddata = r_senddata;
  assign bus.dma_req     = (r_fstate == F_REQ);
  assign bus.dma_addr    = r_addr;
  assign bus.dma_rnw     = 1'b1;
  assign bus.int_req     = r_int_req;
  assign bus.busy        = r_busy;

endmodule

// File: tb/tb_dma_sd_tx.sv
// Scoreboard bench for dma_sd_tx: sequencer and SPI models, expected bytes queued at each start.
`timescale 1ns/1ps
module tb_dma_sd_tx;
  localparam int BLOCK_LEN = 512;
  localparam int SPI_CYC   = 16;
  localparam int BUDGET    = 15000;
`ifdef DMA_SD_TX_CRC_EN
  localparam int N_TX = BLOCK_LEN + 2;
`else
  localparam int N_TX = BLOCK_LEN;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dma_sd_tx_if bus_if();

  dma_sd_tx #(.BLOCK_LEN(BLOCK_LEN), .CNT_W(11)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [7:0]  exp_q [$];
  logic [21:0] exp_fetch_addr = '0;
  logic [21:0] lat_addr = '0;
  int          acks = 0, n_started = 0, int_cnt = 0;
  int          seq_age = 0, pend_end = 0, spi_cnt = 0;
  bit          spi_stall = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] mem_byte(input logic [21:0] a);
    return a[7:0] ^ {a[12:8], a[15:13]} ^ {2'b10, a[21:16]};
  endfunction

`ifdef DMA_SD_TX_CRC_EN
  function automatic logic [15:0] crc_model(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r = c;
    logic fb;
    for (int b = 7; b >= 0; b--) begin
      fb = r[15] ^ d[b];
      r  = {r[14:0], 1'b0};
      if (fb) r = r ^ 16'h1021;
    end
    return r;
  endfunction
`endif

  // Sequencer slot: ack one cycle after req is seen, dma_end three cycles after ack.
  initial begin
    bus_if.dma_ack = 1'b0;
    bus_if.dma_end = 1'b0;
    bus_if.dma_rd  = 8'h00;
    forever begin
      @(posedge clk); #1;
      bus_if.dma_ack = 1'b0;
      bus_if.dma_end = 1'b0;
      if (!rst_n) begin
        pend_end = 0;
        seq_age  = 0;
      end else if (pend_end > 0) begin
        pend_end--;
        if (pend_end == 0) begin
          bus_if.dma_end = 1'b1;
          bus_if.dma_rd  = mem_byte(lat_addr);
        end
      end else if (bus_if.dma_req) begin
        if (seq_age >= 1) begin
          check_val("dma_addr", bus_if.dma_addr, exp_fetch_addr);
          check_val("dma_rnw", bus_if.dma_rnw, 1);
          exp_fetch_addr = exp_fetch_addr + 22'd1;
          lat_addr       = bus_if.dma_addr;
          bus_if.dma_ack = 1'b1;
          pend_end       = 3;
          seq_age        = 0;
          acks++;
        end else begin
          seq_age++;
        end
      end else begin
        seq_age = 0;
      end
    end
  end

  // SPI master: busy for SPI_CYC cycles per byte; each started byte is checked against the queue.
  initial begin
    bus_if.sd_rdy = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (rst_n && bus_if.sd_start) begin
        n_started++;
        if (exp_q.size() == 0) check_val("sd_unexpected", exp_q.size(), 1);
        else                   check_val("sd_data", bus_if.sd_senddata, exp_q.pop_front());
        spi_cnt = SPI_CYC;
      end
      if (spi_cnt > 0) spi_cnt--;
      bus_if.sd_rdy = (spi_cnt == 0) && !spi_stall;
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (bus_if.int_req) begin
        int_cnt++;
        check_val("busy_at_int", bus_if.busy, 0);
      end
    end
  end

  task automatic reg_write(input logic [1:0] sel, input logic [7:0] val);
    bus_if.module_select = 1'b1;
    bus_if.write_strobe  = 1'b1;
    bus_if.regsel        = sel;
    bus_if.din           = val;
    @(negedge clk);
    bus_if.module_select = 1'b0;
    bus_if.write_strobe  = 1'b0;
  endtask

  task automatic reg_read(input logic [1:0] sel, output logic [7:0] val);
    bus_if.regsel = sel;
    #1;
    val = bus_if.dout;
  endtask

  task automatic set_addr(input logic [21:0] a);
    reg_write(2'd0, a[7:0]);
    reg_write(2'd1, a[15:8]);
    reg_write(2'd2, {2'b00, a[21:16]});
  endtask

  task automatic check_addr(input string tag, input logic [21:0] a);
    logic [7:0] v;
    reg_read(2'd0, v); check_val({tag, "_addr0"}, v, a[7:0]);
    reg_read(2'd1, v); check_val({tag, "_addr1"}, v, a[15:8]);
    reg_read(2'd2, v); check_val({tag, "_addr2"}, v, {2'b00, a[21:16]});
  endtask

  task automatic push_block(input logic [21:0] a);
    logic [21:0] p;
`ifdef DMA_SD_TX_CRC_EN
    logic [15:0] crc;
    crc = 16'h0000;
`endif
    p = a;
    for (int i = 0; i < BLOCK_LEN; i++) begin
      exp_q.push_back(mem_byte(p));
`ifdef DMA_SD_TX_CRC_EN
      crc = crc_model(crc, mem_byte(p));
`endif
      p = p + 22'd1;
    end
`ifdef DMA_SD_TX_CRC_EN
    exp_q.push_back(crc[15:8]);
    exp_q.push_back(crc[7:0]);
`endif
    exp_fetch_addr = a;
  endtask

  task automatic wait_int(input string tag, input int base);
    int n = 0;
    while (int_cnt == base && n < BUDGET) begin @(negedge clk); n++; end
    check_val({tag, "_int_count"}, int_cnt - base, 1);
  endtask

  task automatic wait_started(input string tag, input int target);
    int n = 0;
    while (n_started < target && n < BUDGET) begin @(negedge clk); n++; end
    if (n >= BUDGET) check_val({tag, "_start_timeout"}, n_started, target);
  endtask

  task automatic wait_acks(input string tag, input int target);
    int n = 0;
    while (acks < target && n < BUDGET) begin @(negedge clk); n++; end
    if (n >= BUDGET) check_val({tag, "_ack_timeout"}, acks, target);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (bus_if.busy && n < BUDGET) begin @(negedge clk); n++; end
    check_val({tag, "_idle"}, bus_if.busy, 0);
  endtask

  task automatic finish_xfer(input string tag, input int st0, input int i0, input logic [21:0] end_addr);
    logic [7:0] v;
    wait_int(tag, i0);
    repeat (4) @(negedge clk);
    check_val({tag, "_sd_count"}, n_started - st0, N_TX);
    check_val({tag, "_queue_left"}, exp_q.size(), 0);
    check_val({tag, "_busy"}, bus_if.busy, 0);
    reg_read(2'd3, v);
    check_val({tag, "_status"}, v, 8'h00);
    check_addr(tag, end_addr);
    $display("xfer %s: %0d bytes sent, end address 0x%06h", tag, n_started - st0, end_addr);
  endtask

  initial begin
    logic [7:0] v;
    int st0, i0, a0, ak, maxd, d;
    bus_if.module_select = 1'b0;
    bus_if.write_strobe  = 1'b0;
    bus_if.regsel        = 2'd0;
    bus_if.din           = 8'h00;

    repeat (3) @(negedge clk);
    check_val("rst_busy", bus_if.busy, 0);
    check_val("rst_dma_req", bus_if.dma_req, 0);
    check_val("rst_sd_start", bus_if.sd_start, 0);
    check_val("rst_int_req", bus_if.int_req, 0);
    check_val("rst_senddata", bus_if.sd_senddata, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check_addr("rst", 22'h000000);
    reg_read(2'd3, v);
    check_val("rst_status", v, 8'h00);

    reg_write(2'd3, 8'h00);
    @(negedge clk);
    check_val("idle_noop_busy", bus_if.busy, 0);

    // Basic transfer
    st0 = n_started; i0 = int_cnt;
    set_addr(22'h012345);
    push_block(22'h012345);
    reg_write(2'd3, 8'h01);
    reg_read(2'd3, v);
    check_val("t1_status_busy", v, 8'h80);
    finish_xfer("t1", st0, i0, 22'h012545);

    // Address wrap with a 200-cycle SPI stall mid-block
    st0 = n_started; i0 = int_cnt;
    set_addr(22'h3FFF00);
    push_block(22'h3FFF00);
    a0 = acks;
    reg_write(2'd3, 8'h01);
    wait_started("t2", st0 + 100);
    spi_stall = 1'b1;
    maxd = 0;
    d = 0;
    repeat (200) begin
      @(negedge clk);
      d = (acks - a0) - (n_started - st0);
      if (d > maxd) maxd = d;
    end
    check_val("t2_stall_max_ahead", maxd, 2);
    check_val("t2_stall_fill", d, 2);
    check_val("t2_stall_req_low", bus_if.dma_req, 0);
    spi_stall = 1'b0;
    finish_xfer("t2", st0, i0, 22'h000100);

    // Abort while the 100th read awaits dma_end
    st0 = n_started; i0 = int_cnt;
    set_addr(22'h100000);
    push_block(22'h100000);
    a0 = acks;
    reg_write(2'd3, 8'h01);
    wait_acks("t3", a0 + 100);
    @(negedge clk);
    reg_write(2'd3, 8'h00);
    st0 = n_started; ak = acks;
    wait_idle("t3");
    repeat (40) @(negedge clk);
    check_val("t3_no_sd_after_abort", n_started, st0);
    check_val("t3_no_req_after_abort", acks, ak);
    check_val("t3_no_int", int_cnt, i0);
    reg_read(2'd3, v);
    check_val("t3_status", v, 8'h00);
    check_addr("t3", 22'h100064);
    $display("xfer t3: aborted after %0d reads", acks - a0);
    exp_q.delete();

    // Restart from the current address; address writes and a second start while busy are ignored
    st0 = n_started; i0 = int_cnt;
    push_block(22'h100064);
    reg_write(2'd3, 8'h01);
    wait_started("t4", st0 + 50);
    set_addr(22'h2AAAAA);
    reg_write(2'd3, 8'h01);
    reg_read(2'd3, v);
    check_val("t4_status_busy", v, 8'h80);
    finish_xfer("t4", st0, i0, 22'h100264);

    // Reset in the middle of a transfer
    st0 = n_started;
    set_addr(22'h055555);
    push_block(22'h055555);
    reg_write(2'd3, 8'h01);
    wait_started("t5", st0 + 5);
    rst_n = 1'b0;
    #1;
    check_val("t5_rst_busy", bus_if.busy, 0);
    check_val("t5_rst_dma_req", bus_if.dma_req, 0);
    check_val("t5_rst_sd_start", bus_if.sd_start, 0);
    check_val("t5_rst_senddata", bus_if.sd_senddata, 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_addr("t5_rst", 22'h000000);
    $display("xfer t5: reset after %0d bytes", n_started - st0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
